// File: rtl/bus_mux_pkg.sv
// ----------------------------------------------------------------------------
// bus_mux_pkg
// Shared definitions for the registered CPU bus multiplexer:
//   - default data width and source count
//   - symbolic source indices for the register file and special registers
//   - source-selection mode encodings
// ----------------------------------------------------------------------------
package bus_mux_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 24;

    // Source indices on the shared bus
    localparam int R0     = 0;
    localparam int R1     = 1;
    localparam int R2     = 2;
    localparam int R3     = 3;
    localparam int R4     = 4;
    localparam int R5     = 5;
    localparam int R6     = 6;
    localparam int R7     = 7;
    localparam int R8     = 8;
    localparam int R9     = 9;
    localparam int R10    = 10;
    localparam int R11    = 11;
    localparam int R12    = 12;
    localparam int R13    = 13;
    localparam int R14    = 14;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int C      = 23;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_ARB    = 1'b1
    } mode_e;

endpackage

// File: rtl/bus_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Scans pointer+1, pointer+2, ...
// (modulo N) and picks the first requester. The pointer register lives in
// the parent.
// Ports:
//   req     in  N   request vector
//   pointer in  SW  index of the last winner (lowest priority next round)
//   enable  in  1   when low, no grant is produced
//   grant   out N   one-hot grant (zero when nothing is found)
//   winner  out SW  index of the granted source
//   found   out 1   a requester was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 24,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] winner,
    output logic          found
);

    // Rotating priority scan starting just after the pointer
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        if (enable) begin
            for (int k = 1; k <= N; k++) begin
                idx = int'(pointer) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end else begin
                    idx = idx;
                end
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = SW'(idx);
                end else begin
                    found  = found;
                end
            end
            if (found) begin
                grant[winner] = 1'b1;
            end else begin
                grant = '0;
            end
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/bus_mux_rr.sv
// ----------------------------------------------------------------------------
// bus_mux_rr
// Registered N-source bus multiplexer with direct or round-robin source
// selection and a valid/ready output holding register.
// Optional parity feature: define BUS_MUX_RR_PARITY_EN.
// Ports:
//   clock      in  1    rising-edge clock
//   clear      in  1    synchronous active-high reset
//   src_data   in  N*W  packed sources, source i at [i*W +: W]
//   src_req    in  N    per-source request (arbitrated mode)
//   src_gnt    out N    combinational one-hot grant in the capture cycle
//   mode_arb   in  1    0 = direct select, 1 = round-robin
//   sel        in  SW   direct-mode source index
//   out_data   out W    registered bus value
//   out_src    out SW   index of the source held in out_data
//   out_valid  out 1    out_data holds an unconsumed value
//   out_ready  in  1    consumer accepts out_data this cycle
//   err_badsel out 1    one-cycle pulse: out-of-range sel was captured
//   src_par    in  N    (parity build) even parity per source
//   out_par    out 1    (parity build) parity bit registered with out_data
//   err_parity out 1    (parity build) one-cycle pulse on parity mismatch
// ----------------------------------------------------------------------------
module bus_mux_rr
    import bus_mux_pkg::*;
#(
    parameter  int W  = W_DEF,
    parameter  int N  = N_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [N*W-1:0] src_data,
    input  logic [N-1:0]   src_req,
    output logic [N-1:0]   src_gnt,
    input  logic           mode_arb,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef BUS_MUX_RR_PARITY_EN
    input  logic [N-1:0]   src_par,
    output logic           out_par,
    output logic           err_parity,
`endif
    output logic           err_badsel
);

    // Even parity: the XOR of data and its parity bit must be zero
    function automatic logic par_bad(input logic [W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    logic [W-1:0]  src_arr_s [N];
    logic [W-1:0]  out_data_d, out_data_q;
    logic [SW-1:0] out_src_d, out_src_q;
    logic          out_valid_d, out_valid_q;
    logic          err_badsel_d, err_badsel_q;
    logic [SW-1:0] ptr_d, ptr_q;
    logic [N-1:0]  gnt_s;
    logic          load_ok_s;
    logic          sel_ok_s;
    logic          arb_en_s;
    logic [N-1:0]  arb_gnt_s;
    logic [SW-1:0] arb_win_s;
    logic          arb_found_s;
`ifdef BUS_MUX_RR_PARITY_EN
    logic          out_par_d, out_par_q;
    logic          err_parity_d, err_parity_q;
`endif

    // Unpack the flat source bus into an indexable array
    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_arr_s[i] = src_data[i*W +: W];
        end
    end

    assign load_ok_s = !out_valid_q || out_ready;
    assign sel_ok_s  = (int'(sel) < N);
    assign arb_en_s  = load_ok_s && (mode_arb == MODE_ARB) && !clear;

    rr_arbiter #(.N(N)) u_arb (
        .req     (src_req),
        .pointer (ptr_q),
        .enable  (arb_en_s),
        .grant   (arb_gnt_s),
        .winner  (arb_win_s),
        .found   (arb_found_s)
    );

    // Next-state selection: stall, direct capture, or arbitrated capture
    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        ptr_d        = ptr_q;
        err_badsel_d = 1'b0;
        gnt_s        = '0;
`ifdef BUS_MUX_RR_PARITY_EN
        out_par_d    = out_par_q;
        err_parity_d = 1'b0;
`endif
        if (clear || !load_ok_s) begin
            // clear wins over any capture; a stall holds everything
            gnt_s = '0;
        end else if (mode_arb == MODE_DIRECT) begin
            out_src_d   = sel;
            out_valid_d = 1'b1;
            if (sel_ok_s) begin
                out_data_d = src_arr_s[sel];
                gnt_s[sel] = 1'b1;
`ifdef BUS_MUX_RR_PARITY_EN
                out_par_d    = src_par[sel];
                err_parity_d = par_bad(src_arr_s[sel], src_par[sel]);
`endif
            end else begin
                out_data_d   = '0;
                err_badsel_d = 1'b1;
`ifdef BUS_MUX_RR_PARITY_EN
                out_par_d    = 1'b0;
`endif
            end
        end else begin
            if (arb_found_s) begin
                out_data_d  = src_arr_s[arb_win_s];
                out_src_d   = arb_win_s;
                out_valid_d = 1'b1;
                ptr_d       = arb_win_s;
                gnt_s       = arb_gnt_s;
`ifdef BUS_MUX_RR_PARITY_EN
                out_par_d    = src_par[arb_win_s];
                err_parity_d = par_bad(src_arr_s[arb_win_s], src_par[arb_win_s]);
`endif
            end else begin
                // nobody asked: drop valid, keep data and pointer
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; pointer resets to N-1 so source 0 has first priority
    always_ff @(posedge clock) begin
        if (clear) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
            err_badsel_q <= 1'b0;
            ptr_q        <= SW'(N - 1);
`ifdef BUS_MUX_RR_PARITY_EN
            out_par_q    <= 1'b0;
            err_parity_q <= 1'b0;
`endif
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            err_badsel_q <= err_badsel_d;
            ptr_q        <= ptr_d;
`ifdef BUS_MUX_RR_PARITY_EN
            out_par_q    <= out_par_d;
            err_parity_q <= err_parity_d;
`endif
        end
    end

    assign src_gnt    = gnt_s;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign out_valid  = out_valid_q;
    assign err_badsel = err_badsel_q;
`ifdef BUS_MUX_RR_PARITY_EN
    assign out_par    = out_par_q;
    assign err_parity = err_parity_q;
`endif

endmodule

// File: tb/tb_bus_mux_rr.sv
// ----------------------------------------------------------------------------
// tb_bus_mux_rr
// Randomized and directed stimulus for bus_mux_rr, compared every cycle
// against a transaction-level reference model of the selection rules.
// ----------------------------------------------------------------------------
module tb_bus_mux_rr;
    import bus_mux_pkg::*;

    localparam int W  = 32;
    localparam int N  = 24;
    localparam int SW = $clog2(N);

    logic           clock;
    logic           clear;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_req;
    logic [N-1:0]   src_gnt;
    logic           mode_arb;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;
    logic           err_badsel;
`ifdef BUS_MUX_RR_PARITY_EN
    logic [N-1:0]   src_par;
    logic           out_par;
    logic           err_parity;
`endif

    bus_mux_rr #(.W(W), .N(N)) dut (
        .clock      (clock),
        .clear      (clear),
        .src_data   (src_data),
        .src_req    (src_req),
        .src_gnt    (src_gnt),
        .mode_arb   (mode_arb),
        .sel        (sel),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef BUS_MUX_RR_PARITY_EN
        .src_par    (src_par),
        .out_par    (out_par),
        .err_parity (err_parity),
`endif
        .err_badsel (err_badsel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [W-1:0] srcv [N];
    logic [W-1:0] m_data;
    int           m_src;
    logic         m_valid;
    logic         m_err;
    int           m_ptr;
    int           last_idx;
`ifdef BUS_MUX_RR_PARITY_EN
    logic         m_par;
    logic         m_perr;
`endif

    int checks;
    int failures;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_sources();
        for (int i = 0; i < N; i++) begin
            srcv[i] = $urandom;
        end
`ifdef BUS_MUX_RR_PARITY_EN
        src_par = N'($urandom);
`endif
    endtask

    // One clock: predict grant, compare it, clock the DUT, compare outputs.
    // Inputs are assumed already set; called just after a rising edge.
    task automatic run_cycle();
        logic [N-1:0] eg;
        int w;
        int idx;
        for (int i = 0; i < N; i++) begin
            src_data[i*W +: W] = srcv[i];
        end
        #2;
        eg = '0;
        last_idx = -1;
        if (clear) begin
            m_data = '0; m_src = 0; m_valid = 1'b0; m_err = 1'b0; m_ptr = N - 1;
`ifdef BUS_MUX_RR_PARITY_EN
            m_par = 1'b0; m_perr = 1'b0;
`endif
        end else begin
            m_err = 1'b0;
`ifdef BUS_MUX_RR_PARITY_EN
            m_perr = 1'b0;
`endif
            if (!m_valid || out_ready) begin
                if (!mode_arb) begin
                    m_src   = int'(sel);
                    m_valid = 1'b1;
                    if (int'(sel) < N) begin
                        eg[sel]  = 1'b1;
                        m_data   = srcv[sel];
                        last_idx = int'(sel);
`ifdef BUS_MUX_RR_PARITY_EN
                        m_par  = src_par[sel];
                        m_perr = ((^srcv[sel]) != src_par[sel]);
`endif
                    end else begin
                        m_data = '0;
                        m_err  = 1'b1;
`ifdef BUS_MUX_RR_PARITY_EN
                        m_par  = 1'b0;
`endif
                    end
                end else begin
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (w < 0 && src_req[idx]) w = idx;
                    end
                    if (w >= 0) begin
                        eg[w]    = 1'b1;
                        m_data   = srcv[w];
                        m_src    = w;
                        m_valid  = 1'b1;
                        m_ptr    = w;
                        last_idx = w;
`ifdef BUS_MUX_RR_PARITY_EN
                        m_par  = src_par[w];
                        m_perr = ((^srcv[w]) != src_par[w]);
`endif
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
        check_val("src_gnt", 64'(src_gnt), 64'(eg));
        @(posedge clock);
        #1;
        check_val("out_valid", 64'(out_valid), 64'(m_valid));
        check_val("err_badsel", 64'(err_badsel), 64'(m_err));
        if (m_valid) begin
            check_val("out_data", 64'(out_data), 64'(m_data));
            check_val("out_src", 64'(out_src), 64'(m_src));
        end
`ifdef BUS_MUX_RR_PARITY_EN
        check_val("err_parity", 64'(err_parity), 64'(m_perr));
        if (m_valid) check_val("out_par", 64'(out_par), 64'(m_par));
`endif
    endtask

    int exp_seq [5] = '{3, 7, 21, 3, 7};

    initial begin
        checks = 0; failures = 0;
        m_data = '0; m_src = 0; m_valid = 1'b0; m_err = 1'b0; m_ptr = N - 1;
        last_idx = -1;
        rand_sources();
        src_data = '0;
        src_req  = N'($urandom);
        mode_arb = 1'($urandom);
        sel      = SW'($urandom);
        out_ready = 1'($urandom);
        clear = 1'b1;
        @(posedge clock);
        #1;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            src_req = N'($urandom); sel = SW'($urandom);
            mode_arb = 1'($urandom); out_ready = 1'($urandom);
            run_cycle();
        end
        check_val("rst_data", 64'(out_data), 64'd0);
        check_val("rst_src", 64'(out_src), 64'd0);

        // First arbitrated capture after reset grants source 0
        clear = 1'b0; mode_arb = 1'b1; src_req = '1; out_ready = 1'b1;
        run_cycle();
        check_val("first_arb", 64'(last_idx), 64'd0);

        // Direct select of PC
        mode_arb = 1'b0; sel = SW'(PC); srcv[PC] = 32'h0000_1234;
        run_cycle();
        check_val("pc_data", 64'(out_data), 64'h0000_1234);
        check_val("pc_src", 64'(out_src), 64'd20);

        // Out-of-range select, then one-cycle pulse clears
        sel = 5'd27;
        run_cycle();
        check_val("bad_data", 64'(out_data), 64'd0);
        check_val("bad_pulse", 64'(err_badsel), 64'd1);
        sel = 5'd2;
        run_cycle();
        check_val("bad_clear", 64'(err_badsel), 64'd0);

        // Round-robin among 3, 7, 21 (pointer is 0 after the first capture)
        mode_arb = 1'b1; src_req = '0;
        src_req[3] = 1'b1; src_req[7] = 1'b1; src_req[21] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            check_val("rr_seq", 64'(last_idx), 64'(exp_seq[i]));
        end

        // Stall for three cycles with changing requests
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_req = N'($urandom);
            run_cycle();
            check_val("stall_gnt", 64'(last_idx), 64'hFFFF_FFFF_FFFF_FFFF);
        end
        out_ready = 1'b1;
        src_req = '0; src_req[3] = 1'b1; src_req[7] = 1'b1; src_req[21] = 1'b1;
        run_cycle();
        check_val("resume", 64'(last_idx), 64'd21);

        // clear mid-stream restarts arbitration at source 0
        src_req = '1;
        clear = 1'b1;
        run_cycle();
        check_val("clr_valid", 64'(out_valid), 64'd0);
        clear = 1'b0;
        run_cycle();
        check_val("clr_restart", 64'(last_idx), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rand_sources();
            clear     = ($urandom_range(0, 49) == 0);
            mode_arb  = 1'($urandom);
            sel       = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       src_req = '0;
                1:       src_req = N'(1) << $urandom_range(0, N - 1);
                default: src_req = N'($urandom);
            endcase
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mux_rr.md
Name: bus_mux_rr

Overview:
- Parametrised, registered successor to the datapath bus multiplexer: N sources of W bits each, one registered bus output.
- Two source-selection modes:
  - Direct: an encoder-driven select picks the source.
  - Arbitrated: round-robin among requesting sources.
- Output uses a valid/ready handshake with a one-deep holding register, so a stalled consumer never loses data.
- Sits between the register file/special registers and the shared CPU bus.

Parameters:
- W, 32, data width of each source and of the bus.
- N, 24, number of sources (minimum 2).
- SW, $clog2(N), derived select/index width; localparam, not overridable.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset; synchronous, active-high.
- src_data  in  N*W  packed source data; source i occupies [i*W +: W].
- src_req  in  N  per-source request; used in arbitrated mode only.
- src_gnt  out  N  one-hot grant, combinational, asserted in the cycle a source is captured.
- mode_arb  in  1  0 = direct select, 1 = round-robin arbitration.
- sel  in  SW  source index in direct mode.
- out_data  out  W  registered bus value.
- out_src  out  SW  index of the source held in out_data.
- out_valid  out  1  out_data holds an unconsumed value.
- out_ready  in  1  consumer accepts out_data this cycle.
- err_badsel  out  1  registered one-cycle pulse: direct-mode sel >= N was captured.

Behaviour:
- Reset: on the clock edge with clear=1:
  - out_data=0, out_src=0, out_valid=0, err_badsel=0.
  - Round-robin pointer=N-1, so source 0 has first priority.
  - clear overrides any capture or handshake in the same cycle.
- load_ok = !out_valid || out_ready. Capture happens only when load_ok=1.
- Latency: data captured at edge k appears on out_data after edge k (1 cycle). Back-to-back captures give full throughput while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_src and out_valid hold.
  - src_gnt=0; pointer unchanged.
- Direct mode (mode_arb=0), when load_ok:
  - sel < N: out_data<=src_data[sel], out_src<=sel, out_valid<=1, src_gnt=onehot(sel). src_req is ignored.
  - sel >= N: out_data<=0, out_src<=sel, out_valid<=1, err_badsel<=1 for one cycle, src_gnt=0.
  - Pointer is not updated.
- Arbitrated mode (mode_arb=1), when load_ok:
  - Winner is the first requesting index scanning pointer+1, pointer+2, ... with wrap-around modulo N.
  - Winner found: capture winner's data, out_src<=winner, out_valid<=1, src_gnt=onehot(winner), pointer<=winner.
  - No request: out_valid<=0, src_gnt=0, data and pointer hold.
- Simultaneous requests: exactly one grant per capture cycle, never more.
- A single persistent requester is granted every free cycle.
- Mode switch takes effect at the next capture. Pointer is preserved across mode switches.
- err_badsel clears on the next edge unless re-triggered.

Optional Feature:
- Macro: BUS_MUX_RR_PARITY_EN.
- Defined:
  - Adds input src_par[N] (even parity per source) and outputs out_par (1) and err_parity (1).
  - out_par is registered alongside out_data.
  - err_parity is a one-cycle registered pulse when the captured source's parity mismatches its data.
  - A bad-sel capture sets out_par=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bus_mux_pkg:
  - Default W and N.
  - Source index constants: R0..R15 = 0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, C=23.
  - Mode encodings MODE_DIRECT=0, MODE_ARB=1.
- One sub-module, rr_arbiter:
  - Parametrised by N.
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant, winner index, found flag.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- clear=1 for 2 cycles with random inputs -> all outputs 0, pointer=N-1; first arbitrated capture with src_req=all-ones grants source 0.
- Direct mode, out_ready=1, sel=20, src_data[PC]=0x0000_1234 -> src_gnt=1<<20 that cycle; next cycle out_data=0x0000_1234, out_src=20, out_valid=1.
- Direct mode, sel=27 (N=24) -> out_data=0, out_valid=1, err_badsel high for exactly one cycle.
- Arbitrated mode, src_req bits 3, 7, 21 held high, out_ready=1 -> grant sequence 3, 7, 21, 3, 7, with out_src matching each following cycle.
- Stall: out_valid=1, out_ready=0 for 3 cycles while src_req changes -> out_data held, src_gnt=0, pointer unchanged; after out_ready=1, capture resumes next cycle with no value lost or duplicated.
- clear asserted mid-stream with out_valid=1 -> out_valid=0 after that edge; no grant in that cycle; arbitration restarts from source 0.
